// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shift unit.
// The step helper keeps the step-size decision in one place for RTL and tools.
package shift_pkg;

    localparam int WIDTH    = 32;
    localparam int SA_W     = 5;
    localparam int BIG_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Large step while enough distance remains, otherwise single-bit steps.
    function automatic logic [SA_W-1:0] next_step(input logic [SA_W-1:0] remaining);
        if (remaining >= SA_W'(BIG_STEP))
            return SA_W'(BIG_STEP);
        else
            return SA_W'(1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the value by BIG_STEP or by one bit.
// Sign fill comes from the current MSB, which arithmetic right shifts never change.
module shift_step
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_step_big,
    input  logic             i_right,
    input  logic             i_arith,
    output logic [WIDTH-1:0] o_shifted
);

    logic w_fill;

    assign w_fill = i_right & i_arith & i_value[WIDTH-1];

    always_comb begin
        o_shifted = i_value;
        case ({i_right, i_step_big})
            2'b00:   o_shifted = {i_value[WIDTH-2:0], 1'b0};
            2'b01:   o_shifted = {i_value[WIDTH-1-BIG_STEP:0], {BIG_STEP{1'b0}}};
            2'b10:   o_shifted = {w_fill, i_value[WIDTH-1:1]};
            2'b11:   o_shifted = {{BIG_STEP{w_fill}}, i_value[WIDTH-1:BIG_STEP]};
            default: o_shifted = i_value;
        endcase
    end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle shift unit with valid/ready handshakes on both sides.
// Shifts BIG_STEP bits per cycle while possible, then one bit per cycle.
module shift_iter
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SA_W-1:0]  in_sa,
    input  logic             in_right,
    input  logic             in_arith,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [SA_W-1:0]  r_remaining;
    logic             r_right;
    logic             r_arith;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [SA_W-1:0]  w_step;
    logic             w_step_big;
    logic [WIDTH-1:0] w_shifted;

    assign w_step     = next_step(r_remaining);
    assign w_step_big = (w_step == SA_W'(BIG_STEP));

    shift_step u_step (
        .i_value    (r_value),
        .i_step_big (w_step_big),
        .i_right    (r_right),
        .i_arith    (r_arith),
        .o_shifted  (w_shifted)
    );

    // Abort outranks every handshake; the unit only accepts work from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_value     <= '0;
            r_remaining <= '0;
            r_right     <= 1'b0;
            r_arith     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && !abort) begin
                        r_value     <= in_data;
                        r_remaining <= in_sa;
                        r_right     <= in_right;
                        r_arith     <= in_arith;
                        r_in_ready  <= 1'b0;
                        if (in_sa == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (abort) begin
                        r_state     <= IDLE;
                        r_remaining <= '0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_value     <= w_shifted;
                        r_remaining <= r_remaining - w_step;
                        if (r_remaining == w_step) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_remaining <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_value;

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter: a transaction-level model checked every
// cycle, plus directed operations with literal results and latencies.
module tb_shift_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_sa;
    logic        in_right;
    logic        in_arith;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks   = 0;
    int failures = 0;

    shift_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sa     (in_sa),
        .in_right  (in_right),
        .in_arith  (in_arith),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from shift semantics.
    function automatic logic [31:0] model_shift(input logic [31:0] d, input int sa,
                                                input bit r, input bit a);
        if (!r) return d << sa;
        if (a)  return 32'($signed(d) >>> sa);
        return d >> sa;
    endfunction

    // Edges from accept (inclusive) until the result is visible.
    function automatic int model_lat(input int sa);
        return sa / 4 + sa % 4 + 1;
    endfunction

    // Transaction model: one pending operation, visible from a known cycle.
    bit          m_pending;
    int          m_cyc;
    int          m_ready_at;
    logic [31:0] m_result;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending  <= 1'b0;
            m_cyc      <= 0;
            m_ready_at <= 0;
            m_result   <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_pending) begin
                if (abort || (m_cyc >= m_ready_at && out_ready))
                    m_pending <= 1'b0;
            end else if (in_valid && !abort) begin
                m_pending  <= 1'b1;
                m_result   <= model_shift(in_data, int'(in_sa), in_right, in_arith);
                m_ready_at <= m_cyc + model_lat(int'(in_sa));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", {31'b0, in_ready}, 32'd1);
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_out_data", out_data, 32'd0);
        end else begin
            check("cyc_in_ready", {31'b0, in_ready}, {31'b0, !m_pending});
            check("cyc_out_valid", {31'b0, out_valid},
                  {31'b0, (m_pending && m_cyc >= m_ready_at)});
            if (m_pending && m_cyc >= m_ready_at)
                check("cyc_out_data", out_data, m_result);
        end
    end

    task automatic present(input logic [31:0] d, input int sa, input bit r, input bit a);
        in_data  = d;
        in_sa    = 5'(sa);
        in_right = r;
        in_arith = a;
        in_valid = 1'b1;
    endtask

    // Waits for in_ready, lets the accept edge pass, drops in_valid.
    task automatic accept_op();
        int n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int edges);
        edges = 1;
        while (!out_valid && edges < 64) begin
            @(posedge clk); #2;
            edges++;
        end
        check("result_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [31:0] d, input int sa,
                         input bit r, input bit a, input logic [31:0] exp_d,
                         input int exp_e);
        int edges;
        check({name, "_model"}, model_shift(d, sa, r, a), exp_d);
        present(d, sa, r, a);
        accept_op();
        wait_result(edges);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_edges"}, 32'(edges), 32'(exp_e));
        $display("op %s data=%h sa=%0d right=%0d arith=%0d -> out=%h edges=%0d",
                 name, d, sa, r, a, out_data, edges);
        @(posedge clk); #2;
    endtask

    initial begin
        int edges;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sa = '0;
        in_right = 1'b0; in_arith = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Async reset in the middle of a long operation.
        present(32'hFF0000FF, 31, 1'b1, 1'b1);
        accept_op();
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_out_data", out_data, 32'd0);
        $display("op midreset in_ready=%0d out_valid=%0d", in_ready, out_valid);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("postreset_in_ready", {31'b0, in_ready}, 32'd1);
        check("postreset_out_valid", {31'b0, out_valid}, 32'd0);

        do_op("sra4",  32'hFF0000FF, 4,  1'b1, 1'b1, 32'hFFF0000F, 2);
        do_op("sra8",  32'hFF0000FF, 8,  1'b1, 1'b1, 32'hFFFF0000, 3);
        do_op("sra31", 32'hFF0000FF, 31, 1'b1, 1'b1, 32'hFFFFFFFF, 11);
        do_op("srl8",  32'hFF0000FF, 8,  1'b1, 1'b0, 32'h00FF0000, 3);
        do_op("srl31", 32'hFF0000FF, 31, 1'b1, 1'b0, 32'h00000001, 11);
        do_op("srl0",  32'hFF0000FF, 0,  1'b1, 1'b0, 32'hFF0000FF, 1);
        do_op("sll12", 32'hFF0000FF, 12, 1'b0, 1'b1, 32'h000FF000, 4);
        do_op("sll31", 32'hFF0000FF, 31, 1'b0, 1'b1, 32'h80000000, 11);
        do_op("sra5",  32'h7000000F, 5,  1'b1, 1'b1, 32'h03800000, 3);

        // Back-pressure with a second request held during BUSY/DONE.
        out_ready = 1'b0;
        present(32'hFF0000FF, 4, 1'b1, 1'b1);
        accept_op();
        present(32'h0000FFFF, 3, 1'b0, 1'b0);
        wait_result(edges);
        check("bp_first_data", out_data, 32'hFFF0000F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_data", out_data, 32'hFFF0000F);
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        $display("op backpressure out=%h held 5 cycles", out_data);
        out_ready = 1'b1;
        @(posedge clk); #2;
        do_op("bp_second", 32'h0000FFFF, 3, 1'b0, 1'b0, 32'h0007FFF8, 4);

        // Abort while idle blocks acceptance.
        present(32'h12345678, 4, 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk); #2;
        check("abort_idle_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        abort    = 1'b0;
        $display("op abort_idle in_ready=%0d", in_ready);

        // Abort in the third BUSY cycle of a long shift.
        present(32'hFF0000FF, 31, 1'b1, 1'b0);
        accept_op();
        @(posedge clk); #2;
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        check("abort_busy_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_busy_out_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            check("abort_no_pulse", {31'b0, out_valid}, 32'd0);
        end
        $display("op abort_busy in_ready=%0d out_valid=%0d", in_ready, out_valid);
        do_op("srl5_after_abort", 32'h000000F0, 5, 1'b1, 1'b0, 32'h00000007, 3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
